// File: rtl/conv_tap_sequencer.sv
// conv_tap_sequencer: sequences one multiply-accumulate pass for a single
// convolution output point. It walks kernel_rom and the input-window buffer
// one tap per cycle over a 3x3, 5x5 or 7x7 kernel. The signed sum is offered
// to the direction-estimation layer on a valid/ready handshake.
//
// Optional build macro: RELU_EN. When defined, the value loaded into result
// is clamped to max(sum, 0). The internal accumulator is not affected.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             request one pass (sampled only in IDLE)
//   kernel_size_in    00=3x3, 01=5x5, 10=7x7, 11=illegal
//   busy              high while a pass is running or its result is pending
//   rom_kernel_size   latched kernel size to kernel_rom
//   rom_addr          tap index to kernel_rom
//   rom_kernel_val    signed coefficient from kernel_rom (same cycle)
//   win_addr          tap index to window buffer (mirrors rom_addr)
//   win_data          signed window sample (same cycle)
//   result            signed accumulated sum
//   result_valid      result available
//   result_ready      downstream accepts result
//   err_bad_size      one-cycle pulse on start with an illegal size
//
// ACC_W must be at least 21 bits so that a 49-tap pass cannot overflow.
module conv_tap_sequencer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        kernel_size_in,
  output logic              busy,
  output logic [1:0]        rom_kernel_size,
  output logic [5:0]        rom_addr,
  input  logic [7:0]        rom_kernel_val,
  output logic [5:0]        win_addr,
  input  logic [DATA_W-1:0] win_data,
  output logic [ACC_W-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              err_bad_size
);

  localparam int unsigned COEF_W = 8;
  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned ADDR_W = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [ADDR_W-1:0]        last_q, last_d;
  logic [1:0]               ksize_q, ksize_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  result_q, result_d;
  logic                     valid_q, valid_d;
  logic                     busy_q, busy_d;
  logic                     err_q, err_d;

  // Full-precision signed tap product, sign-extended into the accumulator.
  logic signed [COEF_W-1:0] coef_s_c;
  logic signed [DATA_W-1:0] samp_s_c;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [ACC_W-1:0]  sum_c;
  logic signed [ACC_W-1:0]  load_val_c;

  assign coef_s_c = rom_kernel_val;
  assign samp_s_c = win_data;
  assign prod_c   = PROD_W'(coef_s_c) * PROD_W'(samp_s_c);
  assign sum_c    = acc_q + ACC_W'(prod_c);

  // Value presented downstream at the end of a pass.
`ifdef RELU_EN
  assign load_val_c = sum_c[ACC_W-1] ? '0 : sum_c;
`else
  assign load_val_c = sum_c;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    last_d   = last_q;
    ksize_d  = ksize_q;
    acc_d    = acc_q;
    result_d = result_q;
    valid_d  = valid_q;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        addr_d = '0;
        if (start) begin
          if (kernel_size_in == 2'b11) begin
            err_d = 1'b1;
          end else begin
            ksize_d = kernel_size_in;
            acc_d   = '0;
            state_d = S_RUN;
            case (kernel_size_in)
              2'b00:   last_d = ADDR_W'(8);
              2'b01:   last_d = ADDR_W'(24);
              default: last_d = ADDR_W'(48);
            endcase
          end
        end
      end

      S_RUN: begin
        acc_d = sum_c;
        if (addr_q == last_q) begin
          result_d = load_val_c;
          valid_d  = 1'b1;
          addr_d   = '0;
          state_d  = S_DONE;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end

      S_DONE: begin
        addr_d = '0;
        // A start coinciding with the accept is dropped: we leave via IDLE.
        if (result_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        addr_d  = '0;
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      last_q   <= '0;
      ksize_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      last_q   <= last_d;
      ksize_q  <= ksize_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign busy            = busy_q;
  assign rom_kernel_size = ksize_q;
  assign rom_addr        = addr_q;
  assign win_addr        = addr_q;
  assign result          = result_q;
  assign result_valid    = valid_q;
  assign err_bad_size    = err_q;

endmodule

// File: tb/tb_conv_tap_sequencer.sv
// Self-checking bench for conv_tap_sequencer. Provides a behavioural
// kernel_rom and window buffer, runs a table of complete passes, then
// hand-written sequences for hold/backpressure, illegal size and mid-pass reset.
//
// Reference kernels held in the bench ROM:
//   3x3: taps 1,3,5,7 = 1, others 0      (coefficient sum 4)
//   5x5: all taps 1 except centre 12 = 0  (coefficient sum 24)
//   7x7: only centre tap 24 = 1           (sum 1, index-weighted sum 24)
module tb_conv_tap_sequencer;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ACC_W  = 24;

  logic              clk;
  logic              rst;
  logic              start;
  logic [1:0]        kernel_size_in;
  logic              busy;
  logic [1:0]        rom_kernel_size;
  logic [5:0]        rom_addr;
  logic [7:0]        rom_kernel_val;
  logic [5:0]        win_addr;
  logic [DATA_W-1:0] win_data;
  logic [ACC_W-1:0]  result;
  logic              result_valid;
  logic              result_ready;
  logic              err_bad_size;

  int checks = 0;
  int errors = 0;
  int win_mode;  // 0: all +1, 1: all -1, 2: sample = window address

  conv_tap_sequencer #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .kernel_size_in (kernel_size_in),
    .busy           (busy),
    .rom_kernel_size(rom_kernel_size),
    .rom_addr       (rom_addr),
    .rom_kernel_val (rom_kernel_val),
    .win_addr       (win_addr),
    .win_data       (win_data),
    .result         (result),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .err_bad_size   (err_bad_size)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] coef(input logic [1:0] ks, input logic [5:0] a);
    case (ks)
      2'b00:   return (a == 6'd1 || a == 6'd3 || a == 6'd5 || a == 6'd7) ? 8'd1 : 8'd0;
      2'b01:   return (a == 6'd12) ? 8'd0 : 8'd1;
      2'b10:   return (a == 6'd24) ? 8'd1 : 8'd0;
      default: return 8'd0;
    endcase
  endfunction

  always_comb begin
    rom_kernel_val = coef(rom_kernel_size, rom_addr);
    case (win_mode)
      0:       win_data = DATA_W'(1);
      1:       win_data = '1;
      default: win_data = DATA_W'(win_addr);
    endcase
  end

  function automatic int out_of(input int raw);
`ifdef RELU_EN
    return (raw < 0) ? 0 : raw;
`else
    return raw;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] ks;
    int         mode;
    int         n;
    int         raw;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int bad;

    vecs[0] = '{ks: 2'b00, mode: 0, n: 9,  raw: 4};
    vecs[1] = '{ks: 2'b01, mode: 0, n: 25, raw: 24};
    vecs[2] = '{ks: 2'b10, mode: 2, n: 49, raw: 24};
    vecs[3] = '{ks: 2'b00, mode: 1, n: 9,  raw: -4};
    vecs[4] = '{ks: 2'b01, mode: 1, n: 25, raw: -24};

    rst = 1'b1; start = 1'b0; kernel_size_in = 2'b00; result_ready = 1'b1; win_mode = 0;
    repeat (3) tick();

    chk("reset_busy", int'(busy), 0);
    chk("reset_valid", int'(result_valid), 0);
    chk("reset_result", int'($signed(result)), 0);
    chk("reset_rom_addr", int'(rom_addr), 0);
    chk("reset_ksize", int'(rom_kernel_size), 0);
    chk("reset_err", int'(err_bad_size), 0);
    rst = 1'b0;
    tick();

    // Back-to-back passes with result_ready high: N+2 cycles each.
    for (int v = 0; v < 5; v++) begin
      win_mode = vecs[v].mode;
      kernel_size_in = vecs[v].ks;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("pass_busy", int'(busy), 1);
      chk("pass_ksize", int'(rom_kernel_size), int'(vecs[v].ks));
      bad = 0;
      for (int t = 0; t < vecs[v].n; t++) begin
        if (int'(rom_addr) != t || win_addr != rom_addr || result_valid || err_bad_size) bad++;
        tick();
      end
      chk("pass_addr_seq", bad, 0);
      chk("pass_valid", int'(result_valid), 1);
      chk("pass_result", int'($signed(result)), out_of(vecs[v].raw));
      chk("pass_done_addr", int'(rom_addr), 0);
      tick();
      chk("pass_accept_valid", int'(result_valid), 0);
      chk("pass_accept_busy", int'(busy), 0);
      chk("pass_result_kept", int'($signed(result)), out_of(vecs[v].raw));
    end

    // 7x7 all-ones with downstream stalled while start keeps pulsing.
    win_mode = 0; kernel_size_in = 2'b10; result_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (49) tick();
    chk("hold_valid", int'(result_valid), 1);
    chk("hold_result", int'($signed(result)), 1);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      start = (k % 2 == 0);
      kernel_size_in = 2'b00;
      tick();
      if (!result_valid || $signed(result) != 1 || !busy || rom_addr != 6'd0) bad++;
    end
    chk("hold_stable", bad, 0);
    chk("hold_ksize", int'(rom_kernel_size), 2);
    start = 1'b1; result_ready = 1'b1;
    tick();
    chk("hold_accept_valid", int'(result_valid), 0);
    chk("hold_accept_busy", int'(busy), 0);
    start = 1'b0;
    tick();
    chk("hold_start_ignored", int'(busy), 0);

    // Illegal kernel size: one-cycle error pulse, no pass started.
    kernel_size_in = 2'b11; start = 1'b1;
    tick();
    start = 1'b0;
    chk("bad_err_pulse", int'(err_bad_size), 1);
    chk("bad_busy", int'(busy), 0);
    tick();
    chk("bad_err_cleared", int'(err_bad_size), 0);
    chk("bad_busy_after", int'(busy), 0);
    chk("bad_ksize_kept", int'(rom_kernel_size), 2);

    // Reset asserted at tap 4 of a 5x5 pass discards the pass.
    kernel_size_in = 2'b01; win_mode = 0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("rst_mid_addr_before", int'(rom_addr), 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_valid", int'(result_valid), 0);
    chk("rst_mid_result", int'($signed(result)), 0);
    chk("rst_mid_addr", int'(rom_addr), 0);
    chk("rst_mid_ksize", int'(rom_kernel_size), 0);
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (result_valid || busy) bad++;
    end
    chk("rst_mid_no_result", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_tap_sequencer.md
Name: conv_tap_sequencer

Overview:
- Sequences one multiply-accumulate pass of a single output point of the convolution.
- Walks the kernel ROM and the input-window buffer tap by tap over a 3x3, 5x5 or 7x7 kernel, one tap per cycle.
- Presents the signed sum to the downstream stage (direction-estimation layer) on a valid/ready handshake.
- Sits between the layer controller, which issues start plus kernel size, and kernel_rom / the window buffer. Both of those are combinational-read.

Parameters:
- DATA_W, 8, signed window-sample width.
- ACC_W, 24, signed accumulator/result width. Must be >= 21; defaults cannot overflow (49 * 2^14 < 2^20).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  request one pass; sampled only in IDLE
- kernel_size_in  in  2  00=3x3 (9 taps), 01=5x5 (25), 10=7x7 (49), 11=illegal
- busy  out  1  high in RUN or DONE
- rom_kernel_size  out  2  latched kernel size to kernel_rom
- rom_addr  out  6  tap index to kernel_rom
- rom_kernel_val  in  8  signed coefficient from kernel_rom, same cycle
- win_addr  out  6  tap index to window buffer; always equals rom_addr
- win_data  in  DATA_W  signed sample, same cycle
- result  out  ACC_W  signed accumulated sum
- result_valid  out  1  result available
- result_ready  in  1  downstream accepts
- err_bad_size  out  1  one-cycle pulse on start with kernel_size_in=11

Behaviour:
- Reset values (rst sampled high on a clk edge): state=IDLE; rom_addr=0, rom_kernel_size=0, acc/result=0, result_valid=0, busy=0, err_bad_size=0.
  - rst overrides all other inputs, including mid-RUN and mid-DONE.
  - A pass in progress is discarded; no result is produced.
- IDLE:
  - start=1 with a legal size: latch size into rom_kernel_size, set N=9/25/49, rom_addr=0, acc=0, go to RUN.
  - start=1 with size 11: err_bad_size=1 for exactly one cycle; stay in IDLE; rom_kernel_size unchanged.
  - start=0: hold.
- RUN:
  - Each edge: acc <= acc + sext(rom_kernel_val) * sext(win_data), full-precision signed product, sign-extended to ACC_W.
  - If rom_addr != N-1: rom_addr <= rom_addr + 1.
  - If rom_addr == N-1: result <= final sum (including this tap), result_valid <= 1, rom_addr <= 0, go to DONE.
  - start is ignored; kernel_size_in changes are ignored.
- DONE:
  - result and result_valid are held stable while result_ready=0.
  - result_ready=1: result_valid <= 0, go to IDLE. result keeps its last value.
  - start asserted in the same cycle as the accept is ignored; a new start is accepted from IDLE on the next cycle at the earliest.
- Latency: start sampled on edge E0; the N taps are accumulated on edges E1..EN; result_valid is high after EN. Back-to-back passes cost N+2 cycles each with result_ready tied high.
- rom_addr stays 0 in IDLE and DONE.
- busy = (state != IDLE).
- err_bad_size is only generated in IDLE.

Optional Feature:
- Macro RELU_EN.
- Defined: value loaded into result is max(sum, 0); a negative sum yields result=0. The internal accumulator is unaffected.
- Undefined: result is the raw signed sum.
- Timing and handshake are identical in both builds.

Test Plan:
- 3x3, win_data=1 for all taps, result_ready=1 → result_valid after 9 RUN cycles; result=4; rom_addr sequence 0..8.
- 5x5, win_data=1 → result=24 after 25 cycles. Then 7x7 with win_data=win_addr → result=24 after 49 cycles.
- 3x3, win_data=-1 → result=-4 without RELU_EN; result=0 with RELU_EN.
- 7x7, win_data=1, result_ready held 0 for 5 cycles while start pulses → result=1 stable, result_valid stays high, no new pass; accepted on result_ready=1, then IDLE.
- start with kernel_size_in=11 → err_bad_size high exactly 1 cycle, busy stays 0. Separately, rst=1 at tap 4 of a 5x5 pass → next cycle IDLE, result=0, result_valid=0, rom_addr=0.
